// File: rtl/cla_sub8_pipe.sv
// Two-stage pipelined 8-bit subtractor d = a - b - bin with 4-bit lookahead groups.
// Stage 1 resolves the low nibble and inter-nibble carry; stage 2 resolves the high nibble and flags.
module cla_sub8_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] d,
    output logic       bout,
    output logic       ovf,
    output logic       zero
);

    // Returns {carry_out, sum[3:0]} of x + y + cin, all carries from lookahead terms.
    function automatic logic [4:0] lookahead4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       cin
    );
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic       s1_valid;
    logic [3:0] s1_d_lo;
    logic       s1_c4;
    logic [3:0] s1_a_hi;
    logic [3:0] s1_b_hi;
    logic       s1_a7;
    logic       s1_b7;

    logic       in_xfer;
    logic       adv2;
    logic [4:0] lo_sum;
    logic [4:0] hi_sum;
    logic [7:0] d_next;
    logic       c8;

    assign adv2     = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || adv2;
    assign in_xfer  = in_valid && in_ready;

    // Subtraction as a + ~b + !bin: the inverted borrow-in is the carry-in.
    always_comb begin
        lo_sum = lookahead4(a[3:0], ~b[3:0], ~bin);
        hi_sum = lookahead4(s1_a_hi, ~s1_b_hi, s1_c4);
        d_next = {hi_sum[3:0], s1_d_lo};
        c8     = hi_sum[4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_d_lo  <= '0;
            s1_c4    <= 1'b0;
            s1_a_hi  <= '0;
            s1_b_hi  <= '0;
            s1_a7    <= 1'b0;
            s1_b7    <= 1'b0;
        end else begin
            if (in_xfer) begin
                s1_valid <= 1'b1;
                s1_d_lo  <= lo_sum[3:0];
                s1_c4    <= lo_sum[4];
                s1_a_hi  <= a[7:4];
                s1_b_hi  <= b[7:4];
                s1_a7    <= a[7];
                s1_b7    <= b[7];
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (adv2) begin
                out_valid <= 1'b1;
                d         <= d_next;
                bout      <= ~c8;
                ovf       <= (s1_a7 != s1_b7) && (d_next[7] != s1_a7);
                zero      <= ~|d_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
